mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single core memory port between instruction fetch (I) and load/store (D) in the RISC-V core.
- Arbitrates the two requesters, latches the winner's command and drives the shared port with a req/ready handshake.
- Drives `sel` for the external 32-bit address/data muxes and returns read data and completion/error to the owner.
- D has fixed priority; a starvation guard and a response timeout are built in.

## Interface
Parameters:
- STARVE_LIM, 3: maximum consecutive D grants while I is pending; the next grant goes to I.
- TIMEOUT, 15: BUSY cycles without `m_ready` before the transaction is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, held until granted.
- i_addr  in  32  fetch address.
- i_gnt  out  1  fetch command accepted this cycle.
- i_done  out  1  one-cycle fetch completion pulse.
- i_err  out  1  fetch timed out; valid with `i_done`.
- i_rdata  out  32  fetch data; valid with `i_done`.
- d_req  in  1  load/store request, held until granted.
- d_we  in  1  1 = store.
- d_addr  in  32  load/store address.
- d_wdata  in  32  store data.
- d_be  in  4  byte enables.
- d_gnt, d_done, d_err  out  1 each  as the I equivalents.
- d_rdata  out  32  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_be  out  4  memory byte enables.
- m_ready  in  1  memory transfer complete; `m_rdata` valid this cycle.
- m_rdata  in  32  memory read data.
- sel  out  1  current owner: 0 = I, 1 = D.

## Operation
FSM states: IDLE, BUSY_I, BUSY_D.

IDLE:
- Arbitration is combinational.
- Winner:
  - D if `d_req` and not (`i_req` and `streak == STARVE_LIM`).
  - Otherwise I if `i_req`.
- The winner's `x_gnt` = 1 in this cycle.
- On the edge, the command is latched (`addr`, `we`, `wdata`, `be`; I forces `we` = 0 and `be` = 4'hF), `sel` is set and the FSM moves to BUSY_x.
- Requester inputs are don't-care after the grant cycle.

BUSY_x:
- `m_req` = 1; `m_*` driven from the latched command; `gnt` outputs = 0.
- Edge with `m_ready` = 1:
  - `m_rdata` is captured into `x_rdata`.
  - `x_done` pulses in the next cycle.
  - The FSM returns to IDLE, so a new grant may occur in the same cycle as `x_done`.
- Wait counter counts BUSY cycles. If the count reaches TIMEOUT with `m_ready` = 0:
  - `m_req` drops; return to IDLE.
  - Next cycle: `x_done` = 1, `x_err` = 1, `x_rdata` = 0.
- `m_ready` on the timeout cycle counts as success, not an error.
- `m_ready` while IDLE is ignored.

Starvation counter (`streak`, $clog2(STARVE_LIM+1) bits):
- D grant with `i_req` = 1: increments, saturating at STARVE_LIM.
- D grant with `i_req` = 0: cleared.
- Any I grant: cleared.

Reset (asynchronous, any state):
- State IDLE; `streak`, wait counter and latched command cleared.
- All outputs 0, including `sel` = 0 and both `rdata` = 0.
- A transaction in flight is abandoned; no `done` is issued.

## Timing
- Minimum transaction: grant at cycle 0 (IDLE) → `m_req` at cycle 1 → `m_ready` at cycle 1 → `done` at cycle 2.
- Peak throughput: one transfer per 2 cycles.
- `x_done`, `x_err` and `x_rdata` are registered.
- `gnt` is combinational from the `req` inputs in IDLE.
- `m_*` and `sel` are registered and stable for the whole BUSY period.
- At most one `done` per grant. `i_done` and `d_done` are never high together.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encodings ST_IDLE, ST_BUSY_I, ST_BUSY_D;
  - owner constants OWN_I = 0, OWN_D = 1;
  - default constants for STARVE_LIM and TIMEOUT.
- One sub-module: the existing `MUX32` instantiated for the `i_addr`/`d_addr` selection into the command latch, selected by the combinational winner.

## Test plan
- Single fetch: `i_req` = 1, `i_addr` = 0x100, `m_ready` 2 cycles into BUSY with `m_rdata` = 0xDEADBEEF → `m_addr` = 0x100, `m_we` = 0, `i_done` pulse, `i_rdata` = 0xDEADBEEF, `i_err` = 0.
- Simultaneous request: `i_req` and `d_req` both high, store `d_addr` = 0x200, `d_wdata` = 0x12345678, `d_be` = 4'b0011 → D granted first, `sel` = 1, `m_we` = 1 with those values; then I granted.
- Starvation: `i_req` held high, `d_req` held high, `m_ready` always 1 → grant order D, D, D, I, D… (STARVE_LIM = 3).
- Timeout: D load, `m_ready` held 0 → `m_req` drops after 15 BUSY cycles; `d_done` = 1, `d_err` = 1, `d_rdata` = 0.
- Boundary: `m_ready` arrives exactly on the 15th BUSY cycle → success with data, `d_err` = 0.
- Reset mid-BUSY: `rst_n` = 0 during BUSY_D → all outputs 0 immediately and no `d_done`; after release, an `i_req` is granted from IDLE normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM encodings,
// owner codes and default limits.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int STARVE_LIM_DEF = 3;
    localparam int TIMEOUT_DEF    = 15;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared core memory port: command from the arbiter, ready/read data back.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/MUX32.sv
// 32-bit 2:1 mux used for the requester address selection.
module MUX32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto the single core memory
// port, with D priority, an I starvation guard and a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    mem_port_arbiter_if.master mem,
    output logic              sel
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q;
    logic [WW-1:0]     wcnt_q;
    logic              win_i, win_d;
    logic              finish, abort;
    logic [ADDR_W-1:0] addr_mux;

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              sel_q;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_d = state_q;
        win_i   = 1'b0;
        win_d   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_d = rst_n && d_req && !(i_req && streak_q == SW'(STARVE_LIM));
                win_i = rst_n && i_req && !win_d;
                if (win_d)
                    state_d = ST_BUSY_D;
                else if (win_i)
                    state_d = ST_BUSY_I;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem.m_ready) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign i_gnt = win_i;
    assign d_gnt = win_d;

    MUX32 u_addr_mux (
        .a (i_addr),
        .b (d_addr),
        .s (win_d),
        .y (addr_mux)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            streak_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= (state_q == ST_IDLE) ? '0 : wcnt_q + WW'(1);
            if (win_d) begin
                if (!i_req)
                    streak_q <= '0;
                else if (streak_q != SW'(STARVE_LIM))
                    streak_q <= streak_q + SW'(1);
            end else if (win_i) begin
                streak_q <= '0;
            end
        end
    end

    // Command latch: stays stable on the port for the whole BUSY period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= OWN_I;
        end else if (win_d || win_i) begin
            req_q   <= 1'b1;
            we_q    <= win_d & d_we;
            addr_q  <= addr_mux;
            wdata_q <= win_d ? d_wdata : '0;
            be_q    <= win_d ? d_be : {BE_W{1'b1}};
            sel_q   <= win_d ? OWN_D : OWN_I;
        end else if (finish || abort) begin
            req_q <= 1'b0;
        end
    end

    assign mem.m_req   = req_q;
    assign mem.m_we    = we_q;
    assign mem.m_addr  = addr_q;
    assign mem.m_wdata = wdata_q;
    assign mem.m_be    = be_q;
    assign sel         = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_done  <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end else begin
            i_done <= (finish || abort) && state_q == ST_BUSY_I;
            i_err  <= abort && state_q == ST_BUSY_I;
            d_done <= (finish || abort) && state_q == ST_BUSY_D;
            d_err  <= abort && state_q == ST_BUSY_D;
            if (state_q == ST_BUSY_I && (finish || abort))
                i_rdata <= finish ? mem.m_rdata : '0;
            if (state_q == ST_BUSY_D && (finish || abort))
                d_rdata <= finish ? mem.m_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int STARVE_LIM = 3;
    localparam int TIMEOUT    = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, i_done, i_err, d_gnt, d_done, d_err, sel;
    logic [31:0] i_rdata, d_rdata;

    mem_port_arbiter_if mem ();

    mem_port_arbiter #(.STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
        .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
        .d_rdata(d_rdata), .mem(mem), .sel(sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one outstanding transaction, tracked by owner and elapsed cycles.
    int          mo_owner = -1;
    int          mo_el = 0;
    int          mo_streak = 0;
    logic [31:0] mo_addr = '0, mo_wdata = '0, mo_irdata = '0, mo_drdata = '0;
    logic        mo_we = 1'b0, mo_sel = 1'b0;
    logic [3:0]  mo_be = '0;
    logic        mo_idone = 1'b0, mo_ierr = 1'b0, mo_ddone = 1'b0, mo_derr = 1'b0;

    function automatic int winner();
        if (rst_n !== 1'b1 || mo_owner != -1) return -1;
        if (d_req && !(i_req && mo_streak == STARVE_LIM)) return 1;
        if (i_req) return 0;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo_owner = -1; mo_el = 0; mo_streak = 0;
            mo_addr = '0; mo_wdata = '0; mo_we = 0; mo_be = '0; mo_sel = 0;
            mo_idone = 0; mo_ierr = 0; mo_ddone = 0; mo_derr = 0;
            mo_irdata = '0; mo_drdata = '0;
        end else begin
            int w;
            w = winner();
            mo_idone = 0; mo_ierr = 0; mo_ddone = 0; mo_derr = 0;
            if (mo_owner == -1) begin
                if (w == 1) begin
                    mo_addr = d_addr; mo_we = d_we; mo_wdata = d_wdata; mo_be = d_be;
                    mo_sel = 1;
                    mo_streak = i_req ? ((mo_streak < STARVE_LIM) ? mo_streak + 1 : STARVE_LIM) : 0;
                end else if (w == 0) begin
                    mo_addr = i_addr; mo_we = 0; mo_be = 4'hF; mo_sel = 0;
                    mo_streak = 0;
                end
                if (w >= 0) begin
                    mo_owner = w;
                    mo_el = 0;
                end
            end else begin
                mo_el++;
                if (mem.m_ready || mo_el == TIMEOUT) begin
                    if (mo_owner == 0) begin
                        mo_idone = 1; mo_ierr = !mem.m_ready;
                        mo_irdata = mem.m_ready ? mem.m_rdata : 32'h0;
                    end else begin
                        mo_ddone = 1; mo_derr = !mem.m_ready;
                        mo_drdata = mem.m_ready ? mem.m_rdata : 32'h0;
                    end
                    mo_owner = -1;
                end
            end
        end
    end

    // Memory responder: 0 never ready, 1 always ready, 2 ready on BUSY cycle lat, 3 random with stalls.
    int          mode = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] rd_val = '0;

    initial begin
        mem.m_ready = 1'b0;
        mem.m_rdata = '0;
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        case (mode)
            1: mem.m_ready = 1'b1;
            2: mem.m_ready = (mo_owner != -1) && (mo_el + 1 == lat);
            3: mem.m_ready = ((cyc % 100) >= 25) && ($urandom % 3 == 0);
            default: mem.m_ready = 1'b0;
        endcase
        mem.m_rdata = (mode == 2) ? rd_val : $urandom;
    end

    // Compare process plus grant recorder, away from the active edge.
    logic saw_i_gnt = 0, saw_d_gnt = 0;
    logic rec_en = 0;
    int   grants[$];

    always @(negedge clk) begin
        int w;
        w = winner();
        saw_i_gnt = i_gnt;
        saw_d_gnt = d_gnt;
        if (rec_en) begin
            if (i_gnt) grants.push_back(0);
            if (d_gnt) grants.push_back(1);
        end
        check("m_i_gnt", {31'b0, i_gnt}, {31'b0, w == 0});
        check("m_d_gnt", {31'b0, d_gnt}, {31'b0, w == 1});
        check("m_req", {31'b0, mem.m_req}, {31'b0, mo_owner != -1});
        check("m_i_done", {30'b0, i_done, i_err}, {30'b0, mo_idone, mo_ierr});
        check("m_d_done", {30'b0, d_done, d_err}, {30'b0, mo_ddone, mo_derr});
        if (mo_owner != -1) begin
            check("m_addr", mem.m_addr, mo_addr);
            check("m_we_be_sel", {26'b0, mem.m_we, mem.m_be, sel}, {26'b0, mo_we, mo_be, mo_sel});
            if (mo_we) check("m_wdata", mem.m_wdata, mo_wdata);
        end
        if (mo_idone) check("m_i_rdata", i_rdata, mo_irdata);
        if (mo_ddone) check("m_d_rdata", d_rdata, mo_drdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts BUSY cycles from the current one until m_req drops (bounded).
    task automatic count_busy(input int start, output int n);
        n = start;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem.m_req) n++;
            else break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int v;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {26'b0, mem.m_req, sel, i_done, d_done, i_err, d_err}, 32'h0);
        check("rst_rdata", i_rdata | d_rdata | mem.m_addr, 32'h0);
        tick();
        rst_n = 1'b1;

        // Single fetch.
        tick();
        i_req = 1; i_addr = 32'h100; mode = 2; lat = 2; rd_val = 32'hDEADBEEF;
        @(negedge clk);
        check("fetch_gnt", {31'b0, i_gnt}, 32'h1);
        tick();
        i_req = 0; i_addr = '0;
        @(negedge clk);
        check("fetch_addr", mem.m_addr, 32'h100);
        check("fetch_we_sel", {30'b0, mem.m_we, sel}, 32'h0);
        count_busy(1, n);
        check("fetch_busy_len", n, 2);
        check("fetch_done_err", {30'b0, i_done, i_err}, 32'h2);
        check("fetch_rdata", i_rdata, 32'hDEADBEEF);

        // Simultaneous I and D: D first, then I.
        tick();
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'b0011;
        mode = 1;
        @(negedge clk);
        check("simul_gnt", {30'b0, d_gnt, i_gnt}, 32'h2);
        tick();
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("simul_sel_we_be", {26'b0, sel, mem.m_we, mem.m_be}, {26'b0, 1'b1, 1'b1, 4'b0011});
        check("simul_addr", mem.m_addr, 32'h200);
        check("simul_wdata", mem.m_wdata, 32'h12345678);
        tick();
        @(negedge clk);
        check("simul_i_gnt_with_done", {30'b0, i_gnt, d_done}, 32'h3);
        tick();
        i_req = 0;
        @(negedge clk);
        check("simul_i_cmd", {26'b0, sel, mem.m_we, mem.m_be}, {26'b0, 1'b0, 1'b0, 4'hF});
        check("simul_i_addr", mem.m_addr, 32'h300);
        repeat (2) tick();

        // Starvation guard.
        grants.delete();
        rec_en = 1;
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; mode = 1;
        repeat (12) tick();
        rec_en = 0;
        i_req = 0; d_req = 0;
        check("starve_ngrants", grants.size(), 6);
        v = 0;
        for (int k = 0; k < 5 && k < grants.size(); k++) v = (v << 1) | grants[k];
        check("starve_order", v, 32'b11101);
        repeat (3) tick();

        // Timeout on a D load.
        d_req = 1; d_we = 0; d_addr = 32'h400; mode = 0;
        @(negedge clk);
        check("to_gnt", {31'b0, d_gnt}, 32'h1);
        tick();
        d_req = 0;
        @(negedge clk);
        count_busy(mem.m_req ? 1 : 0, n);
        check("to_busy_len", n, TIMEOUT);
        check("to_done_err", {30'b0, d_done, d_err}, 32'h3);
        check("to_rdata", d_rdata, 32'h0);

        // Ready on the last allowed BUSY cycle counts as success.
        tick();
        d_req = 1; d_addr = 32'h500; mode = 2; lat = TIMEOUT; rd_val = 32'hCAFEF00D;
        @(negedge clk);
        check("bnd_gnt", {31'b0, d_gnt}, 32'h1);
        tick();
        d_req = 0;
        @(negedge clk);
        count_busy(mem.m_req ? 1 : 0, n);
        check("bnd_busy_len", n, TIMEOUT);
        check("bnd_done_err", {30'b0, d_done, d_err}, 32'h2);
        check("bnd_rdata", d_rdata, 32'hCAFEF00D);

        // Reset in the middle of BUSY_D.
        tick();
        d_req = 1; d_addr = 32'h600; mode = 0;
        tick();
        d_req = 0;
        repeat (3) tick();
        #2;
        rst_n = 0;
        #1;
        check("rstmid_ctl", {27'b0, mem.m_req, sel, d_done, mem.m_we, i_done}, 32'h0);
        check("rstmid_addr_be", mem.m_addr | {28'b0, mem.m_be}, 32'h0);
        check("rstmid_rdata", d_rdata | i_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstmid_no_done", {31'b0, d_done}, 32'h0);
        end
        tick();
        rst_n = 1;
        i_req = 1; i_addr = 32'h700; mode = 1;
        @(negedge clk);
        check("rstmid_i_gnt", {31'b0, i_gnt}, 32'h1);
        tick();
        i_req = 0;
        @(negedge clk);
        check("rstmid_i_addr", mem.m_addr, 32'h700);
        tick();
        @(negedge clk);
        check("rstmid_i_done", {30'b0, i_done, d_done}, 32'h2);

        // Random traffic against the model.
        mode = 3;
        for (int k = 0; k < 1500; k++) begin
            tick();
            if (saw_i_gnt) i_req = 0;
            if (saw_d_gnt) d_req = 0;
            if (!i_req && ($urandom % 3 == 0)) begin
                i_req = 1; i_addr = $urandom;
            end
            if (!d_req && ($urandom % 2 == 0)) begin
                d_req = 1; d_we = $urandom % 2; d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom);
            end
        end
        tick();
        i_req = 0; d_req = 0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
